// File: rtl/registry_access_arbiter.sv
// Round-robin arbiter sharing one customer-registry port between NUM_REQ requesters,
// with a shadow occupancy count. Define REGISTRY_ARB_STATS_EN to add saturating statistics outputs.
module registry_access_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_CUSTOMERS = 10,
    parameter int ID_W          = 8,
    parameter int DATA_W        = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*ID_W-1:0]   req_id,
    input  logic [NUM_REQ*DATA_W-1:0] req_phone,
    input  logic [NUM_REQ*DATA_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_hit,
    output logic                      rsp_err,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_phone,
    output logic [DATA_W-1:0]         rsp_addr,
    output logic [ID_W-1:0]           reg_customer_id,
    output logic [DATA_W-1:0]         reg_phone,
    output logic [DATA_W-1:0]         reg_address,
    output logic                      reg_add,
    output logic                      reg_search,
    input  logic [ID_W-1:0]           found_customer_id,
    input  logic [DATA_W-1:0]         found_phone_number,
    input  logic [DATA_W-1:0]         found_address,
    output logic [3:0]                occupancy
`ifdef REGISTRY_ARB_STATS_EN
    ,
    output logic [15:0]               stat_adds,
    output logic [15:0]               stat_hits,
    output logic [15:0]               stat_misses,
    output logic [15:0]               stat_errs
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic                op_q, op_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   phone_q, phone_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [3:0]          occ_q, occ_d;
    logic                err_q, err_d;
    logic                hit_q, hit_d;
    logic [DATA_W-1:0]   res_phone_q, res_phone_d;
    logic [DATA_W-1:0]   res_addr_q, res_addr_d;

    logic [NUM_REQ-1:0]  grant_s;
    logic [PTR_W-1:0]    grant_idx_s;
    logic                grant_found_s;
    logic                add_ok_s;
    logic                search_hit_s;

    // Round-robin pick: first valid requester at or after the pointer, wrapping.
    always_comb begin
        logic [PTR_W:0] cand_v;
        grant_s       = '0;
        grant_idx_s   = '0;
        grant_found_s = 1'b0;
        cand_v        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_v = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand_v >= (PTR_W+1)'(NUM_REQ)) begin
                cand_v = cand_v - (PTR_W+1)'(NUM_REQ);
            end else begin
                cand_v = cand_v;
            end
            if (!grant_found_s && req_valid[cand_v[PTR_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_v[PTR_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        if (grant_found_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign add_ok_s     = op_q && (id_q != '0) && (occ_q != 4'(MAX_CUSTOMERS));
    // ID 0 is reserved, so it never matches even if the registry echoes zeros.
    assign search_hit_s = (found_customer_id == id_q) && (id_q != '0);

    // Next-state and payload latching for the issue/wait/response sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        op_d        = op_q;
        id_d        = id_q;
        phone_d     = phone_q;
        addr_d      = addr_q;
        occ_d       = occ_q;
        err_d       = err_q;
        hit_d       = hit_q;
        res_phone_d = res_phone_q;
        res_addr_d  = res_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    owner_d     = grant_idx_s;
                    op_d        = req_op[grant_idx_s];
                    id_d        = req_id[grant_idx_s*ID_W +: ID_W];
                    phone_d     = req_phone[grant_idx_s*DATA_W +: DATA_W];
                    addr_d      = req_addr[grant_idx_s*DATA_W +: DATA_W];
                    err_d       = 1'b0;
                    hit_d       = 1'b0;
                    res_phone_d = '0;
                    res_addr_d  = '0;
                    if (grant_idx_s == PTR_W'(NUM_REQ-1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_idx_s + PTR_W'(1);
                    end
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (op_q && !add_ok_s) begin
                    err_d = 1'b1;
                end else if (add_ok_s) begin
                    occ_d = occ_q + 4'd1;
                end else begin
                    err_d = 1'b0;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (op_q) begin
                    hit_d       = 1'b0;
                    res_phone_d = phone_q;
                    res_addr_d  = addr_q;
                end else if (search_hit_s) begin
                    hit_d       = 1'b1;
                    res_phone_d = found_phone_number;
                    res_addr_d  = found_address;
                end else begin
                    hit_d       = 1'b0;
                    res_phone_d = '0;
                    res_addr_d  = '0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            op_q        <= 1'b0;
            id_q        <= '0;
            phone_q     <= '0;
            addr_q      <= '0;
            occ_q       <= 4'd0;
            err_q       <= 1'b0;
            hit_q       <= 1'b0;
            res_phone_q <= '0;
            res_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            id_q        <= id_d;
            phone_q     <= phone_d;
            addr_q      <= addr_d;
            occ_q       <= occ_d;
            err_q       <= err_d;
            hit_q       <= hit_d;
            res_phone_q <= res_phone_d;
            res_addr_q  <= res_addr_d;
        end
    end

    // Output decode from registered state; response fields are zero outside RESP.
    always_comb begin
        rsp_valid = '0;
        if (state_q == ST_RESP) begin
            rsp_valid[owner_q] = 1'b1;
            rsp_hit            = hit_q;
            rsp_err            = err_q;
            rsp_id             = id_q;
            rsp_phone          = res_phone_q;
            rsp_addr           = res_addr_q;
        end else begin
            rsp_hit   = 1'b0;
            rsp_err   = 1'b0;
            rsp_id    = '0;
            rsp_phone = '0;
            rsp_addr  = '0;
        end
    end

    assign req_ready       = (state_q == ST_IDLE) ? grant_s : '0;
    assign reg_customer_id = id_q;
    assign reg_phone       = phone_q;
    assign reg_address     = addr_q;
    assign reg_add         = (state_q == ST_ISSUE) && add_ok_s;
    assign reg_search      = (state_q == ST_ISSUE) && !op_q;
    assign occupancy       = occ_q;

`ifdef REGISTRY_ARB_STATS_EN
    logic [15:0] stat_adds_q, stat_adds_d;
    logic [15:0] stat_hits_q, stat_hits_d;
    logic [15:0] stat_misses_q, stat_misses_d;
    logic [15:0] stat_errs_q, stat_errs_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Bump exactly one counter per completed operation.
    always_comb begin
        stat_adds_d   = stat_adds_q;
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        stat_errs_d   = stat_errs_q;
        if (state_q == ST_RESP) begin
            if (err_q) begin
                stat_errs_d = sat_inc(stat_errs_q);
            end else if (op_q) begin
                stat_adds_d = sat_inc(stat_adds_q);
            end else if (hit_q) begin
                stat_hits_d = sat_inc(stat_hits_q);
            end else begin
                stat_misses_d = sat_inc(stat_misses_q);
            end
        end else begin
            stat_errs_d = stat_errs_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_adds_q   <= 16'd0;
            stat_hits_q   <= 16'd0;
            stat_misses_q <= 16'd0;
            stat_errs_q   <= 16'd0;
        end else begin
            stat_adds_q   <= stat_adds_d;
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
            stat_errs_q   <= stat_errs_d;
        end
    end

    assign stat_adds   = stat_adds_q;
    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_registry_access_arbiter.sv
// Bench for registry_access_arbiter: directed vector table, hand sequences for
// arbitration/reset corners, and random traffic checked against a transaction-level model.
module tb_registry_access_arbiter;

    localparam int NR   = 4;
    localparam int IW   = 8;
    localparam int DW   = 128;
    localparam int MAXC = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        req_valid, req_ready, req_op, rsp_valid;
    logic [NR*IW-1:0]     req_id;
    logic [NR*DW-1:0]     req_phone, req_addr;
    logic                 rsp_hit, rsp_err;
    logic [IW-1:0]        rsp_id;
    logic [DW-1:0]        rsp_phone, rsp_addr;
    logic [IW-1:0]        reg_customer_id;
    logic [DW-1:0]        reg_phone, reg_address;
    logic                 reg_add, reg_search;
    logic [IW-1:0]        found_customer_id;
    logic [DW-1:0]        found_phone_number, found_address;
    logic [3:0]           occupancy;

    registry_access_arbiter #(.NUM_REQ(NR), .MAX_CUSTOMERS(MAXC), .ID_W(IW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_id(req_id), .req_phone(req_phone), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
        .rsp_id(rsp_id), .rsp_phone(rsp_phone), .rsp_addr(rsp_addr),
        .reg_customer_id(reg_customer_id), .reg_phone(reg_phone), .reg_address(reg_address),
        .reg_add(reg_add), .reg_search(reg_search),
        .found_customer_id(found_customer_id), .found_phone_number(found_phone_number),
        .found_address(found_address), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registry stand-in: results appear the cycle after the search strobe; misses return junk.
    logic [IW-1:0] rg_id [MAXC];
    logic [DW-1:0] rg_ph [MAXC];
    logic [DW-1:0] rg_ad [MAXC];
    int            rg_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rg_cnt             <= 0;
            found_customer_id  <= '0;
            found_phone_number <= '0;
            found_address      <= '0;
        end else begin
            if (reg_add && rg_cnt < MAXC) begin
                rg_id[rg_cnt] <= reg_customer_id;
                rg_ph[rg_cnt] <= reg_phone;
                rg_ad[rg_cnt] <= reg_address;
                rg_cnt        <= rg_cnt + 1;
            end
            if (reg_search) begin
                found_customer_id  <= (reg_customer_id == '0) ? '0 : ~reg_customer_id;
                found_phone_number <= 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
                found_address      <= 128'hCAFE_0000_0000_0000_0000_0000_0000_F00D;
                for (int i = MAXC - 1; i >= 0; i--) begin
                    if (i < rg_cnt && rg_id[i] == reg_customer_id) begin
                        found_customer_id  <= rg_id[i];
                        found_phone_number <= rg_ph[i];
                        found_address      <= rg_ad[i];
                    end
                end
            end
        end
    end

    // Transaction-level reference model.
    logic [IW-1:0] m_id [$];
    logic [DW-1:0] m_ph [$];
    logic [DW-1:0] m_ad [$];
    int            m_occ;
    int            m_ptr;

    task automatic model_reset();
        m_id.delete(); m_ph.delete(); m_ad.delete();
        m_occ = 0;
        m_ptr = 0;
    endtask

    task automatic model_op(input bit op, input logic [IW-1:0] id, input logic [DW-1:0] ph,
                            input logic [DW-1:0] ad, output bit hit, output bit err,
                            output logic [DW-1:0] eph, output logic [DW-1:0] ead);
        hit = 1'b0; err = 1'b0; eph = '0; ead = '0;
        if (op) begin
            eph = ph; ead = ad;
            if (id == '0 || m_occ == MAXC) begin
                err = 1'b1;
            end else begin
                m_id.push_back(id); m_ph.push_back(ph); m_ad.push_back(ad);
                m_occ++;
            end
        end else if (id != '0) begin
            foreach (m_id[i]) begin
                if (!hit && m_id[i] == id) begin
                    hit = 1'b1; eph = m_ph[i]; ead = m_ad[i];
                end
            end
        end
    endtask

    function automatic int model_grant(input logic [NR-1:0] mask);
        for (int k = 0; k < NR; k++) begin
            if (mask[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    bit            p_op [NR];
    logic [IW-1:0] p_id [NR];
    logic [DW-1:0] p_ph [NR];
    logic [DW-1:0] p_ad [NR];

    task automatic set_payload(input int r, input bit op, input logic [IW-1:0] id,
                               input logic [DW-1:0] ph, input logic [DW-1:0] ad);
        p_op[r] = op; p_id[r] = id; p_ph[r] = ph; p_ad[r] = ad;
        req_op[r]             = op;
        req_id[r*IW +: IW]    = id;
        req_phone[r*DW +: DW] = ph;
        req_addr[r*DW +: DW]  = ad;
    endtask

    // Drives one grant and checks strobes and response along the T..T+4 timeline; called at a negedge.
    task automatic run_txn(input logic [NR-1:0] mask, input int own, input bit op,
                           input logic [IW-1:0] id, input bit eh, input bit ee,
                           input logic [DW-1:0] eph, input logic [DW-1:0] ead,
                           input int eocc, output int gcyc);
        int n;
        logic [NR-1:0] oh;
        n  = 0;
        oh = NR'(1) << own;
        req_valid = mask;
        #1;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (req_ready == '0) begin
            n_total++;
            $display("FAIL grant_timeout: got no req_ready expected %0h", oh);
            req_valid = '0;
            gcyc = -1;
            return;
        end
        gcyc = cyc;
        chk("req_ready", req_ready, oh);
        @(negedge clk);
        req_valid = mask & ~oh;
        #1;
        chk("reg_add_issue", reg_add, op && !ee);
        chk("reg_search_issue", reg_search, !op);
        chk("reg_customer_id", reg_customer_id, id);
        chk("rsp_valid_issue", rsp_valid, 0);
        @(negedge clk); #1;
        chk("strobes_wait", {reg_add, reg_search}, 0);
        chk("rsp_valid_wait", rsp_valid, 0);
        @(negedge clk); #1;
        chk("rsp_valid_resp", rsp_valid, oh);
        chk("rsp_hit", rsp_hit, eh);
        chk("rsp_err", rsp_err, ee);
        chk("rsp_id", rsp_id, id);
        chk("rsp_phone", rsp_phone, eph);
        chk("rsp_addr", rsp_addr, ead);
        @(negedge clk); #1;
        chk("rsp_valid_after", rsp_valid, 0);
        chk("occupancy", occupancy, eocc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit            rst_b;
        int            r;
        bit            op;
        logic [IW-1:0] id;
        logic [DW-1:0] ph, ad;
        bit            eh, ee;
        logic [DW-1:0] eph, ead;
        int            eocc;
    } vec_t;

    vec_t vt [18];

    initial begin
        int gc, prev;
        logic [NR-1:0] mask;
        bit eh, ee;
        logic [DW-1:0] eph, ead;
        int own;

        vt[0]  = '{1'b1, 0, 1'b0, 8'h00, 128'h0,  128'h0,  1'b0, 1'b0, 128'h0,  128'h0,  0};
        vt[1]  = '{1'b0, 0, 1'b1, 8'h12, 128'h55, 128'hAA, 1'b0, 1'b0, 128'h55, 128'hAA, 1};
        vt[2]  = '{1'b0, 0, 1'b0, 8'h12, 128'h0,  128'h0,  1'b1, 1'b0, 128'h55, 128'hAA, 1};
        vt[3]  = '{1'b0, 0, 1'b0, 8'h77, 128'h0,  128'h0,  1'b0, 1'b0, 128'h0,  128'h0,  1};
        vt[4]  = '{1'b0, 2, 1'b1, 8'h00, 128'h33, 128'h44, 1'b0, 1'b1, 128'h33, 128'h44, 1};
        for (int k = 1; k <= 10; k++) begin
            vt[4+k] = '{(k == 1), k % NR, 1'b1, 8'(k), 128'h1000 + 128'(k), 128'h2000 + 128'(k),
                        1'b0, 1'b0, 128'h1000 + 128'(k), 128'h2000 + 128'(k), k};
        end
        vt[15] = '{1'b0, 1, 1'b1, 8'h0B, 128'h1B, 128'h2B, 1'b0, 1'b1, 128'h1B, 128'h2B, 10};
        vt[16] = '{1'b0, 3, 1'b0, 8'h0B, 128'h0,  128'h0,  1'b0, 1'b0, 128'h0,  128'h0,  10};
        vt[17] = '{1'b0, 2, 1'b0, 8'h07, 128'h0,  128'h0,  1'b1, 1'b0, 128'h1007, 128'h2007, 10};

        rst = 1'b1;
        req_valid = '0; req_op = '0; req_id = '0; req_phone = '0; req_addr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_occupancy", occupancy, 0);
        chk("reset_strobes", {reg_add, reg_search}, 0);
        chk("reset_reg_id", reg_customer_id, 0);
        chk("reset_reg_phone", reg_phone, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 18; i++) begin
            if (vt[i].rst_b) do_reset();
            set_payload(vt[i].r, vt[i].op, vt[i].id, vt[i].ph, vt[i].ad);
            run_txn(NR'(1) << vt[i].r, vt[i].r, vt[i].op, vt[i].id, vt[i].eh, vt[i].ee,
                    vt[i].eph, vt[i].ead, vt[i].eocc, gc);
            req_valid = '0;
        end

        // All requesters search at once from pointer 0.
        do_reset();
        for (int i = 0; i < NR; i++) set_payload(i, 1'b0, 8'(8'h20 + i), 128'h0, 128'h0);
        mask = '1;
        prev = 0;
        for (int g = 0; g < NR; g++) begin
            run_txn(mask, g, 1'b0, 8'(8'h20 + g), 1'b0, 1'b0, 128'h0, 128'h0, 0, gc);
            if (g > 0) chk("grant_spacing", 128'(gc - prev), 128'd4);
            prev = gc;
            mask = mask & ~(NR'(1) << g);
        end
        req_valid = '0;

        // Reset during the WAIT cycle of a search.
        set_payload(0, 1'b1, 8'h41, 128'h61, 128'h71);
        run_txn(4'b0001, 0, 1'b1, 8'h41, 1'b0, 1'b0, 128'h61, 128'h71, 1, gc);
        set_payload(1, 1'b0, 8'h41, 128'h0, 128'h0);
        req_valid = 4'b0010;
        #1;
        chk("mid_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_occupancy", occupancy, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        req_valid = 4'b1010;
        #1;
        chk("ptr_after_reset", req_ready, 4'b0010);
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("no_rsp_after_reset", rsp_valid, 0);
        end
        set_payload(0, 1'b1, 8'h05, 128'h505, 128'h605);
        run_txn(4'b0001, 0, 1'b1, 8'h05, 1'b0, 1'b0, 128'h505, 128'h605, 1, gc);
        req_valid = '0;

        // Random traffic against the reference model.
        do_reset();
        for (int it = 0; it < 60; it++) begin
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                set_payload(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                            {$urandom, $urandom, $urandom, $urandom},
                            {$urandom, $urandom, $urandom, $urandom});
            end
            own = model_grant(mask);
            model_op(p_op[own], p_id[own], p_ph[own], p_ad[own], eh, ee, eph, ead);
            run_txn(mask, own, p_op[own], p_id[own], eh, ee, eph, ead, m_occ, gc);
            m_ptr = (own + 1) % NR;
            req_valid = '0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
